// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiply / restoring divide engine that stalls the core until a one-cycle valid result
// Ports: clk, rst_n (async active-low); start request, op (0 MUL, 1 DIV, 2 REM, 3 DIVU), A, B operands;
//        stall (combinational hold for the core), valid (one-cycle result strobe), Result (held until next completion)
module muldiv_sequencer #(
  parameter int DATA_LENGTH = 32,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic [DATA_LENGTH-1:0] A,
  input  logic [DATA_LENGTH-1:0] B,
  output logic                   stall,
  output logic                   valid,
  output logic [DATA_LENGTH-1:0] Result
);
  localparam int D = DATA_LENGTH;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0] op_r;
  logic [2*D-1:0] p, p_nx;
  logic [D-1:0] m, a_mag, b_mag, spec_res, q_fin, r_fin, fin;
  logic [D:0] sum, rx, diff;
  logic neg_q, neg_r, sgn, a_neg, b_neg, div_zero, ovf;
  assign stall = (state == IDLE && start) || state == BUSY;
  // p holds {high, low}: MUL accumulates into high while the multiplier shifts out of low;
  // divide keeps the partial remainder in high and shifts quotient bits into low
  always_comb begin
    sgn      = op == 2'd1 || op == 2'd2;
    a_neg    = sgn && A[D-1];
    b_neg    = sgn && B[D-1];
    a_mag    = a_neg ? -A : A;
    b_mag    = b_neg ? -B : B;
    div_zero = op != 2'd0 && B == '0;
    ovf      = sgn && A == {1'b1, {(D-1){1'b0}}} && B == '1;
    spec_res = div_zero ? (op == 2'd2 ? A : '1) : (op == 2'd2 ? '0 : A);
    sum      = {1'b0, p[2*D-1:D]} + (p[0] ? {1'b0, m} : '0);
    rx       = {p[2*D-1:D], p[D-1]};
    diff     = rx - {1'b0, m};
    p_nx     = op_r == 2'd0 ? {sum, p[D-1:1]} :
               diff[D] ? {rx[D-1:0], p[D-2:0], 1'b0} : {diff[D-1:0], p[D-2:0], 1'b1};
    q_fin    = neg_q ? -p_nx[D-1:0] : p_nx[D-1:0];
    r_fin    = neg_r ? -p_nx[2*D-1:D] : p_nx[2*D-1:D];
    fin      = op_r == 2'd2 ? r_fin : op_r == 2'd0 ? p_nx[D-1:0] : q_fin;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      p      <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      valid  <= 1'b0;
      Result <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r  <= op;
          cnt   <= '0;
          p     <= {{D{1'b0}}, op == 2'd0 ? B : a_mag};
          m     <= op == 2'd0 ? A : b_mag;
          neg_q <= op == 2'd1 && (a_neg ^ b_neg);
          neg_r <= op == 2'd2 && a_neg;
          if (div_zero || ovf) begin
            Result <= spec_res;
            valid  <= 1'b1;
            state  <= DONE;
          end else
            state <= BUSY;
        end
        BUSY: begin
          p   <= p_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_WIDTH'(D - 1)) begin
            Result <= fin;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
